instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 109 ++++++++++
 tb/tb_instr_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads a synchronous instruction memory
// and hands each returned byte to the control unit with a one-cycle valid pulse.
module instr_fetch #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    IR_WIDTH    = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [IR_WIDTH-1:0]   HALT_OPCODE = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  imem_rd_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [IR_WIDTH-1:0]   imem_data,
  output logic [IR_WIDTH-1:0]   IR_Output,
  output logic                  ir_valid,
  output logic                  busy,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HALT
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [IR_WIDTH-1:0]   ir_q;
  logic                  ir_valid_q;
  logic                  rd_en_q;
  logic                  busy_q;
  logic                  halted_q;

  // Every output flag is computed one state ahead so it is a flop, not decode.
  // NOTE: all state here is written with non-blocking assignments so every
  // register samples the values from before the edge, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      ir_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (jump_en) begin
            pc_q <= jump_addr;
          end else if (fetch_req) begin
            state_q <= S_REQ;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_REQ: begin
          if (jump_en) begin
            pc_q    <= jump_addr;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          busy_q <= 1'b0;
          if (jump_en) begin
            // The read already issued is simply dropped; IR keeps its value.
            pc_q    <= jump_addr;
            state_q <= S_IDLE;
          end else begin
            ir_q       <= imem_data;
            pc_q       <= pc_q + 1'b1;
            ir_valid_q <= 1'b1;
            if (imem_data == HALT_OPCODE) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_rd_en = rd_en_q;
  assign imem_addr  = pc_q;
  assign IR_Output  = ir_q;
  assign ir_valid   = ir_valid_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a synchronous memory model and a
// scoreboard queue of expected instructions checked on every ir_valid pulse.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_req;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic       imem_rd_en;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] IR_Output;
  logic       ir_valid;
  logic       busy;
  logic       halted;
  logic [7:0] pc;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  logic       prev_valid = 1'b0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .imem_rd_en (imem_rd_en),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .IR_Output  (IR_Output),
    .ir_valid   (ir_valid),
    .busy       (busy),
    .halted     (halted),
    .pc         (pc)
  );

  // Synchronous memory: data appears the cycle after the read strobe, and
  // garbage otherwise so a mistimed capture is visible.
  always @(posedge clk) begin
    if (imem_rd_en) imem_data <= mem[imem_addr];
    else            imem_data <= 8'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every delivered instruction must match the oldest
  // expected entry, and valid must never stay high two cycles running.
  always @(negedge clk) begin
    if (ir_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", 32'(ir_valid), 32'd0);
      end else begin
        check("sb_ir", 32'(IR_Output), 32'(exp_q.pop_front()));
      end
      check("sb_valid_not_back_to_back", 32'(prev_valid), 32'd0);
    end
    prev_valid <= (ir_valid === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    mem[4] = 8'h55; mem[8'h20] = 8'h77; mem[8'h30] = 8'h66;
    mem[8'hFF] = 8'h10;
    fetch_req = 1'b0; jump_en = 1'b0; jump_addr = '0;

    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fetch_req = 1'($urandom); jump_en = 1'($urandom); jump_addr = 8'($urandom);
      tick();
    end
    fetch_req = 1'b0; jump_en = 1'b0; jump_addr = '0;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ir", 32'(IR_Output), 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_rd_en", 32'(imem_rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    tick();

    // Single fetch from address 0
    fetch_req = 1'b1; exp_q.push_back(8'h01);
    tick();
    fetch_req = 1'b0;
    check("single_t1_rd_en", 32'(imem_rd_en), 32'd1);
    check("single_t1_addr", 32'(imem_addr), 32'd0);
    check("single_t1_busy", 32'(busy), 32'd1);
    tick();
    check("single_t2_rd_en", 32'(imem_rd_en), 32'd0);
    check("single_t2_busy", 32'(busy), 32'd1);
    tick();
    check("single_t3_ir", 32'(IR_Output), 32'h01);
    check("single_t3_valid", 32'(ir_valid), 32'd1);
    check("single_t3_pc", 32'(pc), 32'd1);
    check("single_t3_busy", 32'(busy), 32'd0);
    tick();
    check("single_t4_valid", 32'(ir_valid), 32'd0);
    check("single_t4_addr", 32'(imem_addr), 32'd1);

    // Back-to-back with fetch_req held high
    rst = 1'b1; tick(); rst = 1'b0;
    fetch_req = 1'b1;
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 7) fetch_req = 1'b0;
      check($sformatf("b2b_valid_c%0d", k), 32'(ir_valid), (k % 3 == 0) ? 32'd1 : 32'd0);
      check($sformatf("b2b_busy_c%0d", k), 32'(busy), (k % 3 == 0) ? 32'd0 : 32'd1);
    end
    check("b2b_last_ir", 32'(IR_Output), 32'h03);
    check("b2b_pc", 32'(pc), 32'd3);
    tick();
    check("b2b_no_extra_rd", 32'(imem_rd_en), 32'd0);
    check("b2b_no_extra_busy", 32'(busy), 32'd0);

    // PC wrap from all-ones to zero
    jump_en = 1'b1; jump_addr = 8'hFF;
    tick();
    jump_en = 1'b0;
    check("wrap_jump_pc", 32'(pc), 32'hFF);
    check("wrap_jump_no_rd", 32'(imem_rd_en), 32'd0);
    fetch_req = 1'b1; exp_q.push_back(8'h10);
    tick(); fetch_req = 1'b0;
    check("wrap_addr", 32'(imem_addr), 32'hFF);
    tick(); tick();
    check("wrap_ir", 32'(IR_Output), 32'h10);
    check("wrap_pc", 32'(pc), 32'd0);

    // Jump abort in WAIT
    jump_en = 1'b1; jump_addr = 8'h04; tick(); jump_en = 1'b0;
    fetch_req = 1'b1; tick(); fetch_req = 1'b0;
    check("abortw_addr", 32'(imem_addr), 32'h04);
    tick();
    jump_en = 1'b1; jump_addr = 8'h20;
    tick();
    jump_en = 1'b0;
    check("abortw_valid", 32'(ir_valid), 32'd0);
    check("abortw_ir", 32'(IR_Output), 32'h10);
    check("abortw_pc", 32'(pc), 32'h20);
    check("abortw_busy", 32'(busy), 32'd0);
    fetch_req = 1'b1; exp_q.push_back(8'h77);
    tick(); fetch_req = 1'b0;
    check("abortw_refetch_rd", 32'(imem_rd_en), 32'd1);
    tick(); tick();
    check("abortw_refetch_ir", 32'(IR_Output), 32'h77);
    check("abortw_refetch_pc", 32'(pc), 32'h21);

    // Jump abort in REQ
    fetch_req = 1'b1; tick(); fetch_req = 1'b0;
    jump_en = 1'b1; jump_addr = 8'h30;
    tick();
    jump_en = 1'b0;
    check("abortr_pc", 32'(pc), 32'h30);
    check("abortr_busy", 32'(busy), 32'd0);
    tick();
    check("abortr_valid", 32'(ir_valid), 32'd0);
    check("abortr_ir", 32'(IR_Output), 32'h77);

    // Jump and fetch together in IDLE: jump wins, fetch dropped
    jump_en = 1'b1; fetch_req = 1'b1; jump_addr = 8'h40;
    tick();
    jump_en = 1'b0; fetch_req = 1'b0;
    check("jf_pc", 32'(pc), 32'h40);
    check("jf_no_rd", 32'(imem_rd_en), 32'd0);
    check("jf_busy", 32'(busy), 32'd0);
    tick();
    check("jf_no_rd_later", 32'(imem_rd_en), 32'd0);

    // Halt instruction
    rst = 1'b1; tick(); rst = 1'b0;
    mem[0] = 8'hFF;
    fetch_req = 1'b1; exp_q.push_back(8'hFF);
    tick(); fetch_req = 1'b0;
    tick();
    check("halt_pre_halted", 32'(halted), 32'd0);
    tick();
    check("halt_ir", 32'(IR_Output), 32'hFF);
    check("halt_valid", 32'(ir_valid), 32'd1);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc), 32'd1);
    fetch_req = 1'b1; jump_en = 1'b1; jump_addr = 8'h50;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("halt_hold_rd_%0d", k), 32'(imem_rd_en), 32'd0);
      check($sformatf("halt_hold_pc_%0d", k), 32'(pc), 32'd1);
      check($sformatf("halt_hold_halted_%0d", k), 32'(halted), 32'd1);
      check($sformatf("halt_hold_ir_%0d", k), 32'(IR_Output), 32'hFF);
    end
    fetch_req = 1'b0; jump_en = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    check("halt_rst_halted", 32'(halted), 32'd0);
    check("halt_rst_pc", 32'(pc), 32'd0);
    check("halt_rst_ir", 32'(IR_Output), 32'd0);
    tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
